// File: rtl/fb_draw_arbiter.sv
// Round-robin arbiter sharing one framebuffer write port between two drawing engines.
// Two-stage pipeline: accept and bounds-check, then linear address and write strobe.
module fb_draw_arbiter #(
    parameter int CORDW     = 9,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240,
    parameter int ADDRW     = 17,
    parameter int DATAW     = 4,
    parameter int BURST     = 16,
    parameter int WIN_ONLY  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             win,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CORDW-1:0] req0_x,
    input  logic [CORDW-1:0] req0_y,
    input  logic [DATAW-1:0] req0_cidx,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CORDW-1:0] req1_x,
    input  logic [CORDW-1:0] req1_y,
    input  logic [DATAW-1:0] req1_cidx,
    output logic             fb_we,
    output logic [ADDRW-1:0] fb_addr,
    output logic [DATAW-1:0] fb_cidx,
    output logic             owner,
    output logic             drop,
    output logic             busy
);
    localparam int CNTW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int CW1  = CORDW + 1;
    localparam logic [CNTW-1:0]  BURST_MAX = CNTW'(BURST - 1);
    localparam logic [CORDW:0]   FB_W_LIM  = CW1'(FB_WIDTH);
    localparam logic [CORDW:0]   FB_H_LIM  = CW1'(FB_HEIGHT);
    localparam logic [ADDRW-1:0] FB_W_A    = ADDRW'(FB_WIDTH);

    logic            owner_q, owner_d;
    logic [CNTW-1:0] burst_cnt_q, burst_cnt_d;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_oob_q, s1_oob_d;
    logic [CORDW-1:0] s1_x_q, s1_x_d;
    logic [CORDW-1:0] s1_y_q, s1_y_d;
    logic [DATAW-1:0] s1_cidx_q, s1_cidx_d;

    logic             fb_we_q, fb_we_d;
    logic             drop_q, drop_d;
    logic [ADDRW-1:0] fb_addr_q, fb_addr_d;
    logic [DATAW-1:0] fb_cidx_q, fb_cidx_d;

    logic             en;
    logic             owner_valid, other_valid;
    logic             grant_owner, grant_other;
    logic             grant0, grant1;
    logic             accept;
    logic [CORDW-1:0] sel_x, sel_y;
    logic [DATAW-1:0] sel_cidx;

    // Handshake: a pixel moves on a rising edge where valid && ready; ready is
    // combinational and valid must never wait on ready.
    always_comb begin
        en          = (WIN_ONLY == 0) || win;
        owner_valid = owner_q ? req1_valid : req0_valid;
        other_valid = owner_q ? req0_valid : req1_valid;
        grant_owner = owner_valid && (!other_valid || (burst_cnt_q < BURST_MAX));
        grant_other = !grant_owner && other_valid;
        grant0      = owner_q ? grant_other : grant_owner;
        grant1      = owner_q ? grant_owner : grant_other;
        req0_ready  = !rst && en && grant0;
        req1_ready  = !rst && en && grant1;
        accept      = req0_ready || req1_ready;
        sel_x       = grant1 ? req1_x    : req0_x;
        sel_y       = grant1 ? req1_y    : req0_y;
        sel_cidx    = grant1 ? req1_cidx : req0_cidx;
    end

    // Priority state freezes entirely while the write window is closed.
    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (en) begin
            if (accept && grant_owner) begin
                if (burst_cnt_q != BURST_MAX) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end else if (accept && grant_other) begin
                owner_d     = !owner_q;
                burst_cnt_d = '0;
            end else if (!owner_valid) begin
                burst_cnt_d = '0;
            end
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_cidx_d  = s1_cidx_q;
        s1_oob_d   = s1_oob_q;
        if (accept) begin
            s1_x_d    = sel_x;
            s1_y_d    = sel_y;
            s1_cidx_d = sel_cidx;
            s1_oob_d  = ({1'b0, sel_x} >= FB_W_LIM) || ({1'b0, sel_y} >= FB_H_LIM);
        end
    end

    // Off-screen pixels leave address and data untouched so the port only moves on real writes.
    always_comb begin
        fb_we_d   = s1_valid_q && !s1_oob_q;
        drop_d    = s1_valid_q && s1_oob_q;
        fb_addr_d = fb_addr_q;
        fb_cidx_d = fb_cidx_q;
        if (fb_we_d) begin
            fb_addr_d = ADDRW'(s1_y_q) * FB_W_A + ADDRW'(s1_x_q);
            fb_cidx_d = s1_cidx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= 1'b0;
            burst_cnt_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_oob_q    <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_cidx_q   <= '0;
            fb_we_q     <= 1'b0;
            drop_q      <= 1'b0;
            fb_addr_q   <= '0;
            fb_cidx_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_oob_q    <= s1_oob_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_cidx_q   <= s1_cidx_d;
            fb_we_q     <= fb_we_d;
            drop_q      <= drop_d;
            fb_addr_q   <= fb_addr_d;
            fb_cidx_q   <= fb_cidx_d;
        end
    end

    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_cidx = fb_cidx_q;
    assign owner   = owner_q;
    assign drop    = drop_q;
    assign busy    = s1_valid_q || fb_we_q;

endmodule
